// File: rtl/pipeline_if_fq.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_if_fq
// Description : Instruction-fetch queue. Accepts a fetch line of LINE_INSNS
//               instructions, enqueues the instructions from the PC's word
//               offset to the end of the line, tracks each entry's PC, and
//               presents the two oldest instructions to decode.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1                    clock
//   reset        in   1                    synchronous active-high reset
//   pc           in   ADDR_LEN             fetch PC of the current line
//   line_valid   in   1                    idata holds a valid line for pc
//   idata        in   LINE_INSNS*INSN_LEN  fetch line, word k at k*INSN_LEN
//   fetch_ready  out  1                    line accepted if line_valid
//   npc          out  ADDR_LEN             next fetch PC
//   flush        in   1                    redirect, empties the queue
//   flush_pc     in   ADDR_LEN             redirect target
//   deq_ready    in   1                    decode takes all valid outputs
//   inst1/inst2  out  INSN_LEN             head / head+1 instructions
//   pc1          out  ADDR_LEN             PC of inst1
//   valid1/2     out  1                    inst1 / inst2 valid
//   count        out  clog2(DEPTH)+1       occupied entries
// ============================================================================
module pipeline_if_fq #(
  parameter int LINE_INSNS = 4,
  parameter int DEPTH      = 8,
  parameter int ADDR_LEN   = 32,
  parameter int INSN_LEN   = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_LEN-1:0]            pc,
  input  logic                           line_valid,
  input  logic [LINE_INSNS*INSN_LEN-1:0] idata,
  output logic                           fetch_ready,
  output logic [ADDR_LEN-1:0]            npc,
  input  logic                           flush,
  input  logic [ADDR_LEN-1:0]            flush_pc,
  input  logic                           deq_ready,
  output logic [INSN_LEN-1:0]            inst1,
  output logic [INSN_LEN-1:0]            inst2,
  output logic [ADDR_LEN-1:0]            pc1,
  output logic                           valid1,
  output logic                           valid2,
  output logic [$clog2(DEPTH):0]         count
);

  localparam int c_off_w = $clog2(LINE_INSNS);
  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  // Entry storage; validity is carried only by the pointers and count.
  logic [INSN_LEN-1:0] r_mem_insn [DEPTH];
  logic [ADDR_LEN-1:0] r_mem_pc   [DEPTH];

  logic [c_ptr_w-1:0]  r_head;
  logic [c_ptr_w-1:0]  r_tail;
  logic [c_cnt_w-1:0]  r_count;

  logic [c_off_w-1:0]    w_off;
  logic [c_cnt_w-1:0]    w_n_enq;
  logic [c_cnt_w-1:0]    w_free;
  logic [c_cnt_w-1:0]    w_ndeq;
  logic                  w_accept;
  logic [ADDR_LEN-1:0]   w_line_base;
  logic [LINE_INSNS-1:0] w_lane_mask;
  logic [c_ptr_w-1:0]    w_head1;

  logic                w_wr_en   [LINE_INSNS];
  logic [c_ptr_w-1:0]  w_wr_idx  [LINE_INSNS];
  logic [ADDR_LEN-1:0] w_wr_pc   [LINE_INSNS];
  logic [INSN_LEN-1:0] w_wr_insn [LINE_INSNS];

  // Byte-offset bits of the PC never select anything.
  logic w_unused_pc_lsbs;
  assign w_unused_pc_lsbs = &{1'b0, pc[1:0]};

  assign w_off       = pc[2 +: c_off_w];
  assign w_n_enq     = c_cnt_w'(LINE_INSNS) - c_cnt_w'(w_off);
  assign w_free      = c_cnt_w'(DEPTH) - r_count;
  assign fetch_ready = !reset && !flush && (w_free >= w_n_enq);
  assign w_accept    = line_valid && fetch_ready;
  assign w_line_base = {pc[ADDR_LEN-1:c_off_w+2], {(c_off_w+2){1'b0}}};

  always_comb begin
    npc = pc;
    if (flush) begin
      npc = flush_pc;
    end else if (w_accept) begin
      npc = w_line_base + ADDR_LEN'(4 * LINE_INSNS);
    end
  end

  // Lanes at or above the PC offset are written; lane k lands k-off slots
  // past the tail so the line stays in ascending order.
  assign w_lane_mask = {LINE_INSNS{1'b1}} << w_off;

  for (genvar k = 0; k < LINE_INSNS; k++) begin : g_lane
    assign w_wr_en[k]   = w_accept && w_lane_mask[k];
    assign w_wr_idx[k]  = r_tail + c_ptr_w'(k) - c_ptr_w'(w_off);
    assign w_wr_pc[k]   = w_line_base + ADDR_LEN'(4 * k);
    assign w_wr_insn[k] = idata[k*INSN_LEN +: INSN_LEN];
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < LINE_INSNS; k++) begin
      if (w_wr_en[k]) begin
        r_mem_insn[w_wr_idx[k]] <= w_wr_insn[k];
        r_mem_pc[w_wr_idx[k]]   <= w_wr_pc[k];
      end
    end
  end

  assign valid1  = (r_count != '0);
  assign valid2  = (r_count >= c_cnt_w'(2));
  assign w_head1 = r_head + c_ptr_w'(1);
  assign w_ndeq  = deq_ready ? (c_cnt_w'(valid1) + c_cnt_w'(valid2)) : '0;

  assign inst1 = valid1 ? r_mem_insn[r_head]  : '0;
  assign pc1   = valid1 ? r_mem_pc[r_head]    : '0;
  assign inst2 = valid2 ? r_mem_insn[w_head1] : '0;
  assign count = r_count;

  // Pointer widths equal log2(DEPTH), so truncating the advance amounts
  // gives the modulo-DEPTH wrap for free.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + c_ptr_w'(w_ndeq);
      r_tail  <= r_tail + (w_accept ? c_ptr_w'(w_n_enq) : '0);
      r_count <= r_count + (w_accept ? w_n_enq : '0) - w_ndeq;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_if_fq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_if_fq
// Description : Self-checking bench for pipeline_if_fq: directed vector table
//               followed by randomized traffic against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_if_fq;

  localparam int LINE_INSNS = 4;
  localparam int DEPTH      = 8;
  localparam int ADDR_LEN   = 32;
  localparam int INSN_LEN   = 32;

  logic                           clk = 1'b0;
  logic                           reset;
  logic [ADDR_LEN-1:0]            pc;
  logic                           line_valid;
  logic [LINE_INSNS*INSN_LEN-1:0] idata;
  logic                           fetch_ready;
  logic [ADDR_LEN-1:0]            npc;
  logic                           flush;
  logic [ADDR_LEN-1:0]            flush_pc;
  logic                           deq_ready;
  logic [INSN_LEN-1:0]            inst1, inst2;
  logic [ADDR_LEN-1:0]            pc1;
  logic                           valid1, valid2;
  logic [$clog2(DEPTH):0]         count;

  pipeline_if_fq #(
    .LINE_INSNS(LINE_INSNS), .DEPTH(DEPTH), .ADDR_LEN(ADDR_LEN), .INSN_LEN(INSN_LEN)
  ) dut (
    .clk(clk), .reset(reset), .pc(pc), .line_valid(line_valid), .idata(idata),
    .fetch_ready(fetch_ready), .npc(npc), .flush(flush), .flush_pc(flush_pc),
    .deq_ready(deq_ready), .inst1(inst1), .inst2(inst2), .pc1(pc1),
    .valid1(valid1), .valid2(valid2), .count(count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        lv;
    logic [31:0] base;
    logic        dq;
    logic        fl;
    logic [31:0] fpc;
    logic        e_fr;
    logic [31:0] e_npc;
    int          e_cnt;
    logic [31:0] e_i1;
    logic [31:0] e_i2;
    logic [31:0] e_pc1;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [31:0] p, input logic lv, input logic [31:0] b,
                     input logic dq, input logic fl, input logic [31:0] fp,
                     input logic efr, input logic [31:0] enpc, input int ecnt,
                     input logic [31:0] ei1, input logic [31:0] ei2, input logic [31:0] epc1);
    vec_t v;
    v.rst = rst; v.pc = p; v.lv = lv; v.base = b; v.dq = dq; v.fl = fl; v.fpc = fp;
    v.e_fr = efr; v.e_npc = enpc; v.e_cnt = ecnt; v.e_i1 = ei1; v.e_i2 = ei2; v.e_pc1 = epc1;
    vecs.push_back(v);
  endtask

  function automatic logic [LINE_INSNS*INSN_LEN-1:0] mk_line(input logic [31:0] b);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  // Reference model state for the random phase
  logic [31:0] mq_i[$];
  logic [31:0] mq_p[$];

  initial begin
    reset = 1'b1; pc = '0; line_valid = 1'b0; idata = '0;
    flush = 1'b0; flush_pc = '0; deq_ready = 1'b0;
    @(posedge clk); #1;

    //  rst pc        lv base   dq fl fpc       fr npc       cnt i1     i2     pc1
    add(1, 32'h100, 1, 32'h90, 0, 0, 32'h0,   0, 32'h100, 0, 0,     0,     0);
    add(0, 32'h100, 1, 32'hA0, 0, 0, 32'h0,   1, 32'h110, 4, 'hA0,  'hA1,  32'h100);
    add(0, 32'h200, 1, 32'hB0, 0, 0, 32'h0,   1, 32'h210, 8, 'hA0,  'hA1,  32'h100);
    add(0, 32'h308, 1, 32'hC0, 1, 0, 32'h0,   0, 32'h308, 6, 'hA2,  'hA3,  32'h108);
    add(0, 32'h200, 1, 32'hC0, 0, 0, 32'h0,   0, 32'h200, 6, 'hA2,  'hA3,  32'h108);
    add(0, 32'h200, 1, 32'hC0, 1, 0, 32'h0,   0, 32'h200, 4, 'hB0,  'hB1,  32'h200);
    add(0, 32'h200, 1, 32'hD0, 0, 0, 32'h0,   1, 32'h210, 8, 'hB0,  'hB1,  32'h200);
    add(0, 32'h200, 0, 32'hD0, 1, 0, 32'h0,   0, 32'h200, 6, 'hB2,  'hB3,  32'h208);
    add(0, 32'h200, 0, 32'hD0, 1, 0, 32'h0,   0, 32'h200, 4, 'hD0,  'hD1,  32'h200);
    add(0, 32'h20C, 1, 32'hE0, 0, 0, 32'h0,   1, 32'h210, 5, 'hD0,  'hD1,  32'h200);
    add(0, 32'h300, 1, 32'h70, 1, 1, 32'h400, 0, 32'h400, 0, 0,     0,     0);
    add(0, 32'h108, 1, 32'hF0, 0, 0, 32'h0,   1, 32'h110, 2, 'hF2,  'hF3,  32'h108);
    add(0, 32'h10C, 1, 32'h50, 1, 0, 32'h0,   1, 32'h110, 1, 'h53,  0,     32'h10C);
    add(0, 32'h500, 0, 32'h50, 1, 0, 32'h0,   1, 32'h500, 0, 0,     0,     0);
    add(0, 32'h600, 1, 32'h60, 0, 0, 32'h0,   1, 32'h610, 4, 'h60,  'h61,  32'h600);
    add(1, 32'h700, 1, 32'h80, 1, 0, 32'h0,   0, 32'h700, 0, 0,     0,     0);
    add(1, 32'h700, 1, 32'h80, 0, 1, 32'h440, 0, 32'h440, 0, 0,     0,     0);

    foreach (vecs[i]) begin
      reset = vecs[i].rst; pc = vecs[i].pc; line_valid = vecs[i].lv;
      idata = mk_line(vecs[i].base); deq_ready = vecs[i].dq;
      flush = vecs[i].fl; flush_pc = vecs[i].fpc;
      #3;
      chk($sformatf("vec%0d fetch_ready", i), 64'(fetch_ready), 64'(vecs[i].e_fr));
      chk($sformatf("vec%0d npc", i), 64'(npc), 64'(vecs[i].e_npc));
      @(posedge clk); #1;
      chk($sformatf("vec%0d count", i), 64'(count), 64'(vecs[i].e_cnt));
      chk($sformatf("vec%0d valid1", i), 64'(valid1), 64'(vecs[i].e_cnt >= 1));
      chk($sformatf("vec%0d valid2", i), 64'(valid2), 64'(vecs[i].e_cnt >= 2));
      chk($sformatf("vec%0d inst1", i), 64'(inst1), 64'(vecs[i].e_i1));
      chk($sformatf("vec%0d inst2", i), 64'(inst2), 64'(vecs[i].e_i2));
      chk($sformatf("vec%0d pc1", i), 64'(pc1), 64'(vecs[i].e_pc1));
    end

    // Randomized traffic: the queue is empty after the reset vectors above.
    begin
      int          lines = 0;
      int          cyc = 0;
      logic [31:0] cur_pc = 32'h800;
      logic [31:0] words[LINE_INSNS];
      while (lines < 20 && cyc < 3000) begin
        int          off, n, sz;
        logic        e_fr, acc;
        logic [31:0] e_npc, base;
        cyc++;
        reset      = ($urandom_range(0, 39) == 0);
        flush      = ($urandom_range(0, 15) == 0);
        line_valid = ($urandom_range(0, 3) != 0);
        deq_ready  = $urandom_range(0, 1) == 1;
        flush_pc   = 32'h1000 + ($urandom_range(0, 63) << 2);
        pc         = cur_pc;
        for (int k = 0; k < LINE_INSNS; k++) begin
          words[k] = $urandom;
          idata[k*INSN_LEN +: INSN_LEN] = words[k];
        end
        off   = (cur_pc >> 2) % LINE_INSNS;
        n     = LINE_INSNS - off;
        sz    = mq_i.size();
        e_fr  = !reset && !flush && (DEPTH - sz >= n);
        acc   = line_valid && e_fr;
        base  = cur_pc & ~32'(4 * LINE_INSNS - 1);
        e_npc = flush ? flush_pc : (acc ? base + 32'(4 * LINE_INSNS) : cur_pc);
        #3;
        chk("rnd fetch_ready", 64'(fetch_ready), 64'(e_fr));
        chk("rnd npc", 64'(npc), 64'(e_npc));
        @(posedge clk); #1;
        if (reset || flush) begin
          mq_i.delete(); mq_p.delete();
        end else begin
          if (deq_ready) begin
            for (int j = 0; j < 2 && mq_i.size() > 0; j++) begin
              void'(mq_i.pop_front()); void'(mq_p.pop_front());
            end
          end
          if (acc) begin
            for (int k = off; k < LINE_INSNS; k++) begin
              mq_i.push_back(words[k]);
              mq_p.push_back(base + 32'(4 * k));
            end
            if (off == 0) lines++;
          end
        end
        cur_pc = e_npc;
        chk("rnd count", 64'(count), 64'(mq_i.size()));
        chk("rnd valid1", 64'(valid1), 64'(mq_i.size() >= 1));
        chk("rnd valid2", 64'(valid2), 64'(mq_i.size() >= 2));
        chk("rnd inst1", 64'(inst1), 64'(mq_i.size() >= 1 ? mq_i[0] : 32'h0));
        chk("rnd pc1", 64'(pc1), 64'(mq_p.size() >= 1 ? mq_p[0] : 32'h0));
        chk("rnd inst2", 64'(inst2), 64'(mq_i.size() >= 2 ? mq_i[1] : 32'h0));
      end
      chk("rnd aligned lines reached", 64'(lines >= 20), 64'(1));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_if_fq.md
PIPELINE_IF_FQ -- requirements
Module: pipeline_if_fq

Interface
REQ-001 SHALL have parameter LINE_INSNS, default 4: instructions per fetch line; power of 2, at least 2.
REQ-002 SHALL have parameter DEPTH, default 8: fetch-queue entries; power of 2, at least LINE_INSNS.
REQ-003 SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-004 SHALL have these ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- pc  in  ADDR_LEN  fetch PC of the current line request
- line_valid  in  1  idata holds a valid line for pc
- idata  in  LINE_INSNS*INSN_LEN  fetch line; instruction k at bits [k*INSN_LEN +: INSN_LEN]
- fetch_ready  out  1  line accepted this cycle if line_valid
- npc  out  ADDR_LEN  next fetch PC
- flush  in  1  redirect; discards all queued instructions
- flush_pc  in  ADDR_LEN  redirect target
- deq_ready  in  1  decode consumes all valid outputs this cycle
- inst1, inst2  out  INSN_LEN  head and head+1 instructions
- pc1  out  ADDR_LEN  PC of inst1
- valid1, valid2  out  1  inst1 / inst2 valid
- count  out  clog2(DEPTH)+1  occupied entries

Function
REQ-005 off = pc[2 +: log2(LINE_INSNS)]; n_enq = LINE_INSNS - off, range 1..LINE_INSNS.
REQ-006 fetch_ready = !reset && !flush && (DEPTH - count >= n_enq), computed from count before this cycle's dequeue.
REQ-007 accept = line_valid && fetch_ready; on accept, instructions off..LINE_INSNS-1 are written in ascending order at the tail; each entry stores its own PC (pc + 4*i).
REQ-008 Instructions below off are never enqueued; a line never wraps to its own word 0.
REQ-009 npc selection:
- flush: flush_pc
- else accept: line-aligned pc + 4*LINE_INSNS
- otherwise: pc
REQ-010 valid1 = (count >= 1); valid2 = (count >= 2); inst1 and pc1 come from the head, inst2 from head+1 modulo DEPTH.
REQ-011 inst1, inst2 and pc1 are zero when their valid is 0.
REQ-012 ndeq = deq_ready ? (valid1 + valid2) : 0; the head pointer advances by ndeq modulo DEPTH.
REQ-013 On simultaneous enqueue and dequeue: count_next = count + (accept ? n_enq : 0) - ndeq; no overflow or underflow is reachable.
REQ-014 Head and tail pointers are log2(DEPTH) bits and wrap silently; FIFO order is preserved across the wrap.
REQ-015 flush takes priority: next cycle count = 0 and head = tail = 0; this cycle's enqueue and dequeue have no effect.
REQ-016 count, valid, inst and pc1 outputs are registered state or decoded from it; fetch_ready and npc are combinational from the current inputs and state.
REQ-017 Entry storage is not cleared; only pointers and count carry validity.

Reset
REQ-018 When reset is high at a clock edge: head, tail and count are set to 0.
REQ-019 In the cycle after reset: valid1 = valid2 = 0, and inst1, inst2, pc1 are 0.
REQ-020 While reset is high: fetch_ready = 0, no enqueue or dequeue takes effect, and npc = pc (flush_pc if flush is high).
REQ-021 Reset asserted mid-operation discards all queued instructions, exactly as flush does.

Verification (LINE_INSNS=4, DEPTH=8)
REQ-022 Aligned fill: after reset, pc=0x100, line_valid=1, idata={A3,A2,A1,A0}, deq_ready=0 -> fetch_ready=1, npc=0x110; next cycle count=4, inst1=A0, inst2=A1, pc1=0x100.
REQ-023 Mid-line fetch: empty queue, pc=0x108 -> 2 entries enqueued (A2 then A3), npc=0x110, pc1=0x108, count=2.
REQ-024 Backpressure:
- count=6, pc=0x200 -> fetch_ready=0, npc=0x200, count unchanged
- same stimulus with deq_ready=1 -> count=4 next cycle, then fetch_ready=1
REQ-025 Odd drain: count=1, deq_ready=1 -> valid2=0, inst2=0; next cycle count=0, valid1=0.
REQ-026 Flush collision: count=5, line_valid=1, deq_ready=1, flush=1, flush_pc=0x400 -> fetch_ready=0, npc=0x400; next cycle count=0.
REQ-027 Wrap and random: 20 aligned lines interleaved with random deq_ready, flush and reset -> dequeued stream and PCs match a scoreboard in order, count matches the model every cycle.
